// File: rtl/square_gen.sv
// Pulse-channel frequency register, period timer, duty sequencer and on/off gating.
// Optional length counter enabled by defining SQUARE_LENGTH_EN.
module square_gen #(
  parameter int PRESCALE_BITS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        slow_clk_en,
  input  logic        cpu_en,
  input  logic        clk256_en,
  input  logic [1:0]  duty,
  input  logic        dac_en,
  input  logic        freq_lo_write,
  input  logic        freq_hi_write,
  input  logic [7:0]  wdata,
  input  logic        length_write,
  input  logic [10:0] sweep_new_freq,
  input  logic        do_freq_sweep,
  output logic [10:0] freq,
  output logic        init,
  output logic        ch_on,
  output logic        wave_out
);

  logic [10:0]              freq_reg, freq_next;
  logic                     init_reg;
  logic                     ch_on_reg, ch_on_next;
  logic                     wave_reg;
  logic [10:0]              timer_reg, timer_next;
  logic [PRESCALE_BITS-1:0] presc_reg, presc_next;
  logic [2:0]               step_reg, step_next;
  logic                     lo_wr, hi_wr, trigger, tick, len_expire;
  logic [7:0]               pattern;

  assign lo_wr   = cpu_en & freq_lo_write;
  assign hi_wr   = cpu_en & freq_hi_write;
  assign trigger = hi_wr & wdata[7];
  assign tick    = slow_clk_en & (&presc_reg);

  // Any CPU frequency byte write blocks the sweep update for the whole cycle.
  always_comb begin
    freq_next = freq_reg;
    if (lo_wr || hi_wr) begin
      if (lo_wr) freq_next[7:0]  = wdata;
      if (hi_wr) freq_next[10:8] = wdata[2:0];
    end else if (do_freq_sweep) begin
      freq_next = sweep_new_freq;
    end
  end

  // Trigger restarts the period from the new frequency and suppresses any tick.
  always_comb begin
    timer_next = timer_reg;
    presc_next = presc_reg;
    step_next  = step_reg;
    if (trigger) begin
      timer_next = 11'h7FF - freq_next;
      presc_next = '0;
    end else if (slow_clk_en) begin
      presc_next = presc_reg + 1'b1;
      if (tick) begin
        if (timer_reg == 11'd0) begin
          timer_next = 11'h7FF - freq_reg;
          step_next  = step_reg + 3'd1;
        end else begin
          timer_next = timer_reg - 11'd1;
        end
      end
    end
  end

  always_comb begin
    case (duty)
      2'b00:   pattern = 8'b0000_0001;
      2'b01:   pattern = 8'b1000_0001;
      2'b10:   pattern = 8'b1000_0111;
      default: pattern = 8'b0111_1110;
    endcase
  end

`ifdef SQUARE_LENGTH_EN
  logic [6:0] len_reg, len_next;
  logic       len_en_reg, len_en_next;

  always_comb begin
    len_next    = len_reg;
    len_expire  = 1'b0;
    len_en_next = hi_wr ? wdata[6] : len_en_reg;
    if (cpu_en && length_write) begin
      len_next = 7'd64 - {1'b0, wdata[5:0]};
    end else if (trigger) begin
      if (len_reg == 7'd0) len_next = 7'd64;
    end else if (slow_clk_en && clk256_en && len_en_reg && len_reg != 7'd0) begin
      len_next   = len_reg - 7'd1;
      len_expire = (len_reg == 7'd1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_reg    <= '0;
      len_en_reg <= 1'b0;
    end else begin
      len_reg    <= len_next;
      len_en_reg <= len_en_next;
    end
  end
`else
  logic unused_len;
  assign unused_len = ^{length_write, clk256_en, wdata[6]};
  assign len_expire = 1'b0;
`endif

  // dac_en low dominates everything, trigger dominates length expiry.
  always_comb begin
    ch_on_next = ch_on_reg;
    if (len_expire) ch_on_next = 1'b0;
    if (trigger)    ch_on_next = 1'b1;
    if (!dac_en)    ch_on_next = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      freq_reg  <= '0;
      init_reg  <= 1'b0;
      ch_on_reg <= 1'b0;
      wave_reg  <= 1'b0;
      timer_reg <= '0;
      presc_reg <= '0;
      step_reg  <= '0;
    end else begin
      freq_reg  <= freq_next;
      init_reg  <= trigger;
      ch_on_reg <= ch_on_next;
      wave_reg  <= pattern[step_reg] & ch_on_reg;
      timer_reg <= timer_next;
      presc_reg <= presc_next;
      step_reg  <= step_next;
    end
  end

  assign freq     = freq_reg;
  assign init     = init_reg;
  assign ch_on    = ch_on_reg;
  assign wave_out = wave_reg;

endmodule

// File: tb/tb_square_gen.sv
// Randomized and directed bench for square_gen against a pulse-count reference model.
// Define SQUARE_LENGTH_EN to also exercise the length counter.
module tb_square_gen;
  logic        clk = 1'b0;
  logic        reset;
  logic        slow_clk_en, cpu_en, clk256_en, dac_en;
  logic [1:0]  duty;
  logic        freq_lo_write, freq_hi_write, length_write, do_freq_sweep;
  logic [7:0]  wdata;
  logic [10:0] sweep_new_freq;
  logic [10:0] freq;
  logic        init, ch_on, wave_out;

  int checks = 0;
  int errors = 0;

  // Reference state: rem_m counts slow_clk_en pulses left until the next duty step.
  logic [10:0] freq_m;
  logic        init_m, ch_m, wave_m;
  logic [2:0]  step_m;
  int          rem_m;
  logic [6:0]  len_m;
  logic        len_en_m;
  logic [7:0]  pat_tbl [4];

  square_gen #(.PRESCALE_BITS(2)) dut (
    .clk(clk), .reset(reset), .slow_clk_en(slow_clk_en), .cpu_en(cpu_en),
    .clk256_en(clk256_en), .duty(duty), .dac_en(dac_en),
    .freq_lo_write(freq_lo_write), .freq_hi_write(freq_hi_write), .wdata(wdata),
    .length_write(length_write), .sweep_new_freq(sweep_new_freq),
    .do_freq_sweep(do_freq_sweep), .freq(freq), .init(init), .ch_on(ch_on),
    .wave_out(wave_out)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    freq_m = '0; init_m = 0; ch_m = 0; wave_m = 0; step_m = '0;
    rem_m = 4; len_m = '0; len_en_m = 0;
  endtask

  task automatic idle_inputs();
    cpu_en = 0; freq_lo_write = 0; freq_hi_write = 0; length_write = 0;
    do_freq_sweep = 0; clk256_en = 0; wdata = '0; sweep_new_freq = '0;
  endtask

  // Applies current inputs for one clock, advances the model, compares outputs.
  task automatic run_cycle();
    logic        lo, hi, trig, ch_n, expire, wave_n;
    logic [10:0] fn;
    logic [2:0]  step_n;
    logic [6:0]  len_n;
    logic        len_en_n;
    int          rem_n;
    lo   = cpu_en & freq_lo_write;
    hi   = cpu_en & freq_hi_write;
    trig = hi & wdata[7];
    fn = freq_m;
    if (lo || hi) begin
      if (lo) fn[7:0]  = wdata;
      if (hi) fn[10:8] = wdata[2:0];
    end else if (do_freq_sweep) fn = sweep_new_freq;
    step_n = step_m;
    rem_n  = rem_m;
    if (trig) rem_n = (2048 - int'(fn)) * 4;
    else if (slow_clk_en) begin
      rem_n = rem_m - 1;
      if (rem_n == 0) begin
        step_n = step_m + 3'd1;
        rem_n  = (2048 - int'(freq_m)) * 4;
      end
    end
    expire = 0; len_n = len_m; len_en_n = len_en_m;
`ifdef SQUARE_LENGTH_EN
    if (hi) len_en_n = wdata[6];
    if (cpu_en && length_write) len_n = 7'(64 - int'(wdata[5:0]));
    else if (trig) begin
      if (len_m == 0) len_n = 7'd64;
    end else if (slow_clk_en && clk256_en && len_en_m && len_m != 0) begin
      len_n  = len_m - 7'd1;
      expire = (len_n == 0);
    end
`endif
    ch_n = ch_m;
    if (expire)  ch_n = 0;
    if (trig)    ch_n = 1;
    if (!dac_en) ch_n = 0;
    wave_n = pat_tbl[duty][step_m] & ch_m;
    @(posedge clk);
    #1;
    freq_m = fn; init_m = trig; ch_m = ch_n; wave_m = wave_n; step_m = step_n;
    rem_m = rem_n; len_m = len_n; len_en_m = len_en_n;
    check_value("freq", 32'(freq), 32'(freq_m));
    check_value("init", 32'(init), 32'(init_m));
    check_value("ch_on", 32'(ch_on), 32'(ch_m));
    check_value("wave_out", 32'(wave_out), 32'(wave_m));
  endtask

  task automatic cpu_write(input string what, input logic [7:0] data);
    cpu_en = 1; wdata = data;
    freq_lo_write = (what == "lo");
    freq_hi_write = (what == "hi");
    length_write  = (what == "len");
    run_cycle();
    $display("write %s data=%02h -> freq=%03h init=%0b ch_on=%0b", what, data, freq, init, ch_on);
    cpu_en = 0; freq_lo_write = 0; freq_hi_write = 0; length_write = 0;
  endtask

  task automatic async_reset_check();
    #2 reset = 1;
    #1;
    check_value("rst_freq", 32'(freq), 32'd0);
    check_value("rst_init", 32'(init), 32'd0);
    check_value("rst_ch_on", 32'(ch_on), 32'd0);
    check_value("rst_wave", 32'(wave_out), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    pat_tbl[0] = 8'b0000_0001;
    pat_tbl[1] = 8'b1000_0001;
    pat_tbl[2] = 8'b1000_0111;
    pat_tbl[3] = 8'b0111_1110;
    idle_inputs();
    slow_clk_en = 0; dac_en = 1; duty = 2'b00;
    reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
    model_reset();
    #1;
    check_value("reset_freq", 32'(freq), 32'd0);
    check_value("reset_ch_on", 32'(ch_on), 32'd0);
    check_value("reset_init", 32'(init), 32'd0);
    check_value("reset_wave", 32'(wave_out), 32'd0);

    // Long period: freq 0x700 steps every 1024 pulses.
    cpu_write("lo", 8'h00);
    cpu_write("hi", 8'h87);
    check_value("trig_init", 32'(init), 32'd1);
    check_value("trig_ch_on", 32'(ch_on), 32'd1);
    slow_clk_en = 1; duty = 2'b11;
    repeat (2200) run_cycle();
    $display("long period run done: step model=%0d", step_m);

    // Shortest period with duty 10: step every 4 pulses.
    duty = 2'b10;
    cpu_write("lo", 8'hFF);
    cpu_write("hi", 8'h87);
    repeat (48) run_cycle();
    $display("fast period run done");

    // Sweep overwrite, then CPU byte beats a simultaneous sweep.
    cpu_write("lo", 8'hF0);
    cpu_write("hi", 8'h87);
    repeat (20) run_cycle();
    sweep_new_freq = 11'h123; do_freq_sweep = 1;
    run_cycle();
    do_freq_sweep = 0;
    check_value("sweep_freq", 32'(freq), 32'h123);
    repeat (60) run_cycle();
    sweep_new_freq = 11'h7AA; do_freq_sweep = 1;
    cpu_write("lo", 8'h55);
    do_freq_sweep = 0;
    check_value("cpu_over_sweep", 32'(freq), 32'h155);
    repeat (20) run_cycle();

`ifdef SQUARE_LENGTH_EN
    cpu_write("len", 8'h3E);
    cpu_write("hi", 8'hC7);
    for (int i = 0; i < 40; i++) begin
      clk256_en = (i % 10 == 9);
      run_cycle();
    end
    clk256_en = 0;
    check_value("len_expired_ch_on", 32'(ch_on), 32'd0);
    check_value("len_expired_wave", 32'(wave_out), 32'd0);
    cpu_write("hi", 8'hC7);
    check_value("len_retrig_ch_on", 32'(ch_on), 32'd1);
    for (int i = 0; i < 100; i++) begin
      clk256_en = (i % 2 == 0);
      run_cycle();
    end
    clk256_en = 0;
    check_value("len64_still_on", 32'(ch_on), 32'd1);
`endif

    // DAC off blocks the trigger but init still pulses.
    dac_en = 0;
    cpu_write("hi", 8'h87);
    check_value("dac_off_init", 32'(init), 32'd1);
    check_value("dac_off_ch_on", 32'(ch_on), 32'd0);
    repeat (8) run_cycle();
    check_value("dac_off_wave", 32'(wave_out), 32'd0);
    dac_en = 1;

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      slow_clk_en    = ($urandom_range(0, 3) != 0);
      clk256_en      = ($urandom_range(0, 15) == 0);
      dac_en         = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 99) == 0) duty = 2'($urandom_range(0, 3));
      do_freq_sweep  = ($urandom_range(0, 99) == 0);
      sweep_new_freq = 11'(11'h7C0 + $urandom_range(0, 63));
      case ($urandom_range(0, 39))
        0: cpu_write("lo", 8'(8'hC0 + $urandom_range(0, 63)));
        1: cpu_write("hi", 8'(($urandom_range(0, 3) << 6) | 7));
        2: cpu_write("len", 8'($urandom_range(0, 255)));
        default: begin
          cpu_en = ($urandom_range(0, 1) == 1);
          run_cycle();
          cpu_en = 0;
        end
      endcase
    end
    idle_inputs();
    dac_en = 1; slow_clk_en = 1;

    // Mid-period reset with the channel running.
    cpu_write("lo", 8'hF8);
    cpu_write("hi", 8'h87);
    repeat (13) run_cycle();
    check_value("pre_reset_ch_on", 32'(ch_on), 32'd1);
    async_reset_check();
    duty = 2'b00;
    repeat (40) run_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
